// File: rtl/fsm_seq_driver_if.sv
// Handshake and button-line bundle between the controlling logic (master)
// and fsm_seq_driver (slave). Optional LED/PASS pair under CHECK_LED_EN.
interface fsm_seq_driver_if #(
    parameter int SEQ_LEN = 10
);
    logic                   start;
    logic                   abort;
    logic [2*SEQ_LEN-1:0]   code;
    logic                   a;
    logic                   b;
    logic                   c;
    logic                   busy;
    logic                   done;
`ifdef CHECK_LED_EN
    logic                   led;
    logic                   pass;

    modport master (output start, abort, code, led,
                    input  a, b, c, busy, done, pass);
    modport slave  (input  start, abort, code, led,
                    output a, b, c, busy, done, pass);
`else
    modport master (output start, abort, code,
                    input  a, b, c, busy, done);
    modport slave  (input  start, abort, code,
                    output a, b, c, busy, done);
`endif
endinterface

// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver: plays a latched 2-bit-per-symbol code out on the A/B/C
// button lines, HOLD_CYC cycles per symbol followed by GAP_CYC low cycles.
// Optional macro CHECK_LED_EN adds the LED input / PASS result output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | lines low, waiting for START (ABORT has priority)
// S_DRIVE | current symbol on the lines, slot counter running down
// S_GAP   | lines low between symbols, slot counter running down
// S_FIN   | one-cycle DONE pulse, back to idle
module fsm_seq_driver #(
    parameter int SEQ_LEN  = 10,
    parameter int HOLD_CYC = 1,
    parameter int GAP_CYC  = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fsm_seq_driver_if.slave  bus_if
);

    localparam int IW   = $clog2(SEQ_LEN + 1);
    localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*SEQ_LEN-1:0] shadow_q, shadow_d;
    logic [2:0]           lines_q, lines_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           sym_d;
    logic                 go;

    assign go = (state_q == S_IDLE) && bus_if.start && !bus_if.abort;

    // Next-state, counters and next registered outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    shadow_d = bus_if.code;
                    idx_d    = '0;
                    cnt_d    = HOLD_LD;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (bus_if.abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (GAP_CYC > 0) begin
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                    cnt_d = HOLD_LD;
                end
            end
            S_GAP: begin
                if (bus_if.abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = HOLD_LD;
                    state_d = S_DRIVE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so the lines are registered
        // and change on the same edge as the state.
        sym_d   = shadow_d[{idx_d, 1'b0} +: 2];
        lines_d = 3'b000;
        if (state_d == S_DRIVE) begin
            case (sym_d)
                2'b01:   lines_d = 3'b100;
                2'b10:   lines_d = 3'b010;
                2'b11:   lines_d = 3'b001;
                default: lines_d = 3'b000;
            endcase
        end
        busy_d = (state_d == S_DRIVE) || (state_d == S_GAP);
        done_d = (state_d == S_FIN);
    end

    // State, counters, shadow code and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            lines_q  <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            lines_q  <= lines_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus_if.a    = lines_q[2];
    assign bus_if.b    = lines_q[1];
    assign bus_if.c    = lines_q[0];
    assign bus_if.busy = busy_q;
    assign bus_if.done = done_q;

`ifdef CHECK_LED_EN
    logic pass_q;

    // PASS captures LED on the edge entering FIN; a new transmission clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pass_q <= 1'b0;
        end else if (go) begin
            pass_q <= 1'b0;
        end else if (state_d == S_FIN) begin
            pass_q <= bus_if.led;
        end
    end

    assign bus_if.pass = pass_q;
`endif

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Scoreboard bench for fsm_seq_driver: two instances (default timing, and
// HOLD/GAP timing), randomized codes, aborts and ignored START/CODE noise.
module tb_fsm_seq_driver;

    localparam int N0 = 10, H0 = 1, G0 = 0;
    localparam int N1 = 2,  H1 = 2, G1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fsm_seq_driver_if #(.SEQ_LEN(N0)) if0 ();
    fsm_seq_driver_if #(.SEQ_LEN(N1)) if1 ();

    fsm_seq_driver #(.SEQ_LEN(N0), .HOLD_CYC(H0), .GAP_CYC(G0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(if0)
    );
    fsm_seq_driver #(.SEQ_LEN(N1), .HOLD_CYC(H1), .GAP_CYC(G1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(if1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // expected per-cycle output while busy or done: {a,b,c,busy,done}
    logic [4:0] exp0[$];
    logic [4:0] exp1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    // Reference model: expand the code into the output trace it should produce.
    task automatic model_push(input int d, input logic [19:0] code, input int cut);
        int n, h, g;
        logic [1:0] s;
        logic [2:0] ln;
        logic [4:0] tr[$];
        n = (d == 0) ? N0 : N1;
        h = (d == 0) ? H0 : H1;
        g = (d == 0) ? G0 : G1;
        for (int i = 0; i < n; i++) begin
            s  = code[2*i +: 2];
            ln = (s == 2'd1) ? 3'b100 : (s == 2'd2) ? 3'b010 : (s == 2'd3) ? 3'b001 : 3'b000;
            for (int j = 0; j < h; j++) tr.push_back({ln, 2'b10});
            for (int j = 0; j < g; j++) tr.push_back(5'b00010);
        end
        tr.push_back(5'b00001);
        for (int k = 0; k < tr.size(); k++) begin
            if (cut == 0 || k < cut) begin
                if (d == 0) exp0.push_back(tr[k]);
                else        exp1.push_back(tr[k]);
            end
        end
    endtask

    task automatic mon(input int d, input logic [4:0] v);
        logic [4:0] e;
        if (v[1] || v[0]) begin
            if (qsize(d) == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut%0d_unexpected: got %b, required no output", d, v);
            end else begin
                e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                check((d == 0) ? "dut0_out" : "dut1_out", v, e);
            end
        end else begin
            check((d == 0) ? "dut0_idle_lines" : "dut1_idle_lines", v[4:2], 3'b000);
        end
    endtask

    // Monitor: compare whatever the DUTs present, away from the active edge.
    always @(negedge clk) begin
        mon(0, {if0.a, if0.b, if0.c, if0.busy, if0.done});
        mon(1, {if1.a, if1.b, if1.c, if1.busy, if1.done});
`ifdef CHECK_LED_EN
        if (if0.done) check("dut0_pass_after_fin", if0.pass, 1'b1);
        if (if0.busy) check("dut0_pass_cleared", if0.pass, 1'b0);
        if (if1.done) check("dut1_pass_after_fin", if1.pass, 1'b1);
        if (if1.busy) check("dut1_pass_cleared", if1.pass, 1'b0);
`endif
    end

    task automatic drive(input int d, input logic s, input logic ab, input logic [19:0] cd);
        if (d == 0) begin
            if0.start = s;
            if0.abort = ab;
            if0.code  = cd;
        end else begin
            if1.start = s;
            if1.abort = ab;
            if1.code  = cd[2*N1-1:0];
        end
    endtask

    // One transmission; cut>0 aborts at edge k+cut; noise scrambles CODE and
    // pulses START while the block is busy or in FIN.
    task automatic run_txn(input int d, input logic [19:0] code, input int cut, input bit noise);
        int t, last, wc;
        t = (d == 0) ? N0 * (H0 + G0) : N1 * (H1 + G1);
        model_push(d, code, cut);
        @(negedge clk);
        drive(d, 1'b1, 1'b0, code);
        last = (cut > 0) ? cut : t + 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (noise)
                drive(d, (c == 3) ? 1'b1 : 1'($urandom % 2), (c == cut),
                      (c == 2) ? 20'h0 : 20'($urandom));
            else
                drive(d, 1'b0, (c == cut), code);
        end
        @(negedge clk);
        drive(d, 1'b0, 1'b0, code);
        wc = 0;
        while (qsize(d) != 0 && wc < 50) begin
            @(negedge clk);
            wc++;
        end
        check((d == 0) ? "dut0_drain" : "dut1_drain", qsize(d), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [19:0] code;
        int d, t, cut;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 20'h0);
        drive(1, 1'b0, 1'b0, 20'h0);
`ifdef CHECK_LED_EN
        if0.led = 1'b1;
        if1.led = 1'b1;
`endif
        @(posedge clk);
        #1;
        check("dut0_reset_out", {if0.a, if0.b, if0.c, if0.busy, if0.done}, 5'b0);
        check("dut1_reset_out", {if1.a, if1.b, if1.c, if1.busy, if1.done}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // default pattern C,-,C,-,B,-,B,-,B,B
        run_txn(0, 20'hA2233, 0, 1'b0);
        // abort at edge 4, then replay from symbol 0
        run_txn(0, 20'hA2233, 4, 1'b0);
        run_txn(0, 20'hA2233, 0, 1'b0);
        // CODE->0 at edge 2 and START at edge 3 while busy are ignored
        run_txn(0, 20'hA2233, 0, 1'b1);

        // ABORT and START together in IDLE: no transmission
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 20'h12345);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 20'h12345);
        repeat (4) @(negedge clk);
        check("abort_wins_busy", if0.busy, 1'b0);

        // HOLD=2, GAP=1: A,A,-,B,B,-, DONE after edge 6
        run_txn(1, 20'h00009, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            d    = r % 2;
            code = 20'($urandom);
            t    = (d == 0) ? N0 * (H0 + G0) : N1 * (H1 + G1);
            cut  = ($urandom % 4 == 0) ? 1 + int'($urandom % t) : 0;
            run_txn(d, code, cut, 1'($urandom % 2));
        end

        // asynchronous reset while symbol 3 is on the lines
        code = 20'($urandom);
        code[7:6] = 2'b01;
        model_push(0, code, 4);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, code);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, code);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_sym3", {if0.a, if0.b, if0.c, if0.busy}, 4'b1001);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_lines", {if0.a, if0.b, if0.c}, 3'b000);
        check("async_rst_busy", if0.busy, 1'b0);
        exp0.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_after_rst", if0.busy, 1'b0);
        run_txn(0, code, 0, 1'b0);

        check("dut0_queue_empty", exp0.size(), 0);
        check("dut1_queue_empty", exp1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_seq_driver.md
Name: fsm_seq_driver

Overview:
- Transmitter for the button-sequence lock FSM: plays a programmed code out as A/B/C button pulses, one symbol per slot. It drives the A/B/C inputs of the detector FSM in both system and self-test configurations.
- Symbol slot length and the idle gap between symbols are programmable. START/BUSY/DONE handshake toward the controlling logic.

Parameters:
- SEQ_LEN, 10, number of symbols per code; range 1..32.
- HOLD_CYC, 1, cycles each symbol is driven; must be >= 1.
- GAP_CYC, 0, all-low cycles inserted after each symbol; 0 means no gap.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- START  input  1  begin transmission; sampled only in IDLE.
- ABORT  input  1  synchronous cancel of a transmission in progress.
- CODE  input  2*SEQ_LEN  symbol i in bits [2i+1:2i]: 00 none, 01 A, 10 B, 11 C. Symbol 0 is sent first.
- A  output  1  button A line, registered.
- B  output  1  button B line, registered.
- C  output  1  button C line, registered.
- BUSY  output  1  transmission in progress.
- DONE  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (async, RST=1): A=B=C=0, BUSY=0, DONE=0, state IDLE, counters 0. Takes effect immediately, including mid-sequence. After release, the block waits in IDLE.
- States:
  - IDLE: lines low. START=1 at edge k latches CODE into an internal shadow register. Symbol 0 appears on A/B/C after edge k, BUSY=1 after edge k, next state DRIVE.
  - DRIVE: the current symbol is held for HOLD_CYC edges total. Then:
    - GAP_CYC>0: go to GAP.
    - otherwise, not the last symbol: advance to the next symbol.
    - otherwise (last symbol): go to FIN.
  - GAP: A=B=C=0 for GAP_CYC edges. Then advance to the next symbol (DRIVE), or go to FIN after the last symbol.
  - FIN: one cycle. A=B=C=0, DONE=1, BUSY=0, next state IDLE.
- Symbol 00 drives all lines low for its slot but still consumes the slot.
- At most one line is high in any cycle.
- Total timing: START at edge k gives a DONE pulse in the cycle after edge k+SEQ_LEN*(HOLD_CYC+GAP_CYC).
- CODE changes while BUSY are ignored; the shadow copy is used.
- START while BUSY or in FIN is ignored; the bench sees no restart.
- ABORT=1 at an edge while BUSY: lines low and BUSY=0 after that edge, no DONE, state IDLE.
- ABORT and START in the same IDLE cycle: ABORT wins, no transmission.
- ABORT in IDLE: no effect.
- Internal counters: symbol index sized ceil(log2(SEQ_LEN+1)); slot counter sized for max(HOLD_CYC, GAP_CYC). No wrap occurs because the index stops at SEQ_LEN-1.

Optional Feature:
- Macro CHECK_LED_EN.
- Defined: adds ports LED (input, 1) and PASS (output, 1, reset 0).
  - On the FIN edge, PASS is loaded with the value of LED sampled at that edge.
  - PASS holds until the next START, which clears it to 0, or until reset.
- Undefined: LED and PASS ports do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-sequence: START, then RST=1 during symbol 3 -> A=B=C=0, BUSY=0 immediately (asynchronous). Release RST -> block idles until a fresh START.
- Defaults, CODE=20'hA2233, START at edge 0 -> line pattern per edge 0..9 is C,-,C,-,B,-,B,-,B,B. BUSY high over edges 0..9; DONE=1 for one cycle after edge 10; all lines 0 afterwards.
- HOLD_CYC=2, GAP_CYC=1, SEQ_LEN=2, CODE=4'b1001 -> A high 2 cycles, 1 low cycle, B high 2 cycles, 1 low cycle. DONE after edge 6.
- ABORT asserted on edge 4 of the default run -> lines 0 and BUSY 0 after edge 4; DONE never pulses. A subsequent START replays the code from symbol 0.
- START pulsed at edge 3 while BUSY, and CODE changed to 0 at edge 2 -> the original sequence completes unchanged and DONE is still after edge 10.
- CHECK_LED_EN defined, LED tied 1 at the FIN edge -> PASS=1 after FIN. Next START -> PASS=0.
